mem_block_copier: RTL and testbench

Word-granular block-copy initiator that drives the data-memory port (Address/WriteData/MemRead/MemWrite/ReadData) from the requester side. On a Start pulse it copies Length consecutive words from SrcAddr to DstAddr by alternating single-word reads and writes. It sits beside the single-cycle datapath as a memory master, for bulk initialisation and relocation of data regions, and shares the memory's single-cycle registered read timing.

---
 rtl/mem_copier_pkg.sv | 17 +
 rtl/mem_copier_addr_gen.sv | 57 +++++
 rtl/mem_block_copier.sv | 151 +++++++++++++++
 tb/tb_mem_block_copier.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_copier_pkg.sv
// Shared types and default sizes for the word-granular block copier.
// Fill mode is gated by the MEM_COPIER_FILL_EN macro in mem_block_copier.
package mem_copier_pkg;

  localparam int unsigned WordSizeDefault = 32;
  localparam int unsigned AddrSizeDefault = 32;
  localparam int unsigned LenSizeDefault  = 16;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRead  = 3'd1,
    StWait  = 3'd2,
    StWrite = 3'd3,
    StDone  = 3'd4
  } state_e;

endpackage

// File: rtl/mem_copier_addr_gen.sv
// Source/destination pointers and remaining word count for the block copier.
// Pointers wrap silently modulo 2^ADDRESS_SIZE.
module mem_copier_addr_gen
  import mem_copier_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE = AddrSizeDefault,
  parameter int unsigned LEN_SIZE     = LenSizeDefault
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic                    step_i,
  input  logic [ADDRESS_SIZE-1:0] src_i,
  input  logic [ADDRESS_SIZE-1:0] dst_i,
  input  logic [LEN_SIZE-1:0]     len_i,
  output logic [ADDRESS_SIZE-1:0] src_o,
  output logic [ADDRESS_SIZE-1:0] dst_o,
  output logic                    cnt_zero_next_o
);

  logic [ADDRESS_SIZE-1:0] src_q, src_d;
  logic [ADDRESS_SIZE-1:0] dst_q, dst_d;
  logic [LEN_SIZE-1:0]     cnt_q, cnt_d;

  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    cnt_d = cnt_q;
    if (load_i) begin
      src_d = src_i;
      dst_d = dst_i;
      cnt_d = len_i;
    end else if (step_i) begin
      src_d = src_q + ADDRESS_SIZE'(1);
      dst_d = dst_q + ADDRESS_SIZE'(1);
      cnt_d = cnt_q - LEN_SIZE'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_q <= '0;
      dst_q <= '0;
      cnt_q <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      cnt_q <= cnt_d;
    end
  end

  assign src_o = src_q;
  assign dst_o = dst_q;
  // True when the step taken this cycle moves the last word.
  assign cnt_zero_next_o = (cnt_q == LEN_SIZE'(1));

endmodule

// File: rtl/mem_block_copier.sv
// Block-copy memory master: alternating single-word reads and writes.
// Define MEM_COPIER_FILL_EN to add the Fill/FillPattern pattern-fill mode.
module mem_block_copier
  import mem_copier_pkg::*;
#(
  parameter int unsigned WORD_SIZE    = WordSizeDefault,
  parameter int unsigned ADDRESS_SIZE = AddrSizeDefault,
  parameter int unsigned LEN_SIZE     = LenSizeDefault
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    Start,
  input  logic [ADDRESS_SIZE-1:0] SrcAddr,
  input  logic [ADDRESS_SIZE-1:0] DstAddr,
  input  logic [LEN_SIZE-1:0]     Length,
`ifdef MEM_COPIER_FILL_EN
  input  logic                    Fill,
  input  logic [WORD_SIZE-1:0]    FillPattern,
`endif
  output logic                    Busy,
  output logic                    Done,
  output logic [ADDRESS_SIZE-1:0] Address,
  output logic [WORD_SIZE-1:0]    WriteData,
  output logic                    MemRead,
  output logic                    MemWrite,
  input  logic [WORD_SIZE-1:0]    ReadData
);

  state_e state_q, state_d;

  logic                    load;
  logic                    step;
  logic                    cnt_zero_next;
  logic [ADDRESS_SIZE-1:0] src_ptr;
  logic [ADDRESS_SIZE-1:0] dst_ptr;
  logic [WORD_SIZE-1:0]    buf_q;
  logic                    fill_start;
  logic                    fill_mode;
  logic [WORD_SIZE-1:0]    fill_word;

  assign load = (state_q == StIdle) && Start;
  assign step = (state_q == StWrite);

  mem_copier_addr_gen #(
    .ADDRESS_SIZE(ADDRESS_SIZE),
    .LEN_SIZE    (LEN_SIZE)
  ) u_addr_gen (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_i         (load),
    .step_i         (step),
    .src_i          (SrcAddr),
    .dst_i          (DstAddr),
    .len_i          (Length),
    .src_o          (src_ptr),
    .dst_o          (dst_ptr),
    .cnt_zero_next_o(cnt_zero_next)
  );

`ifdef MEM_COPIER_FILL_EN
  logic                 fill_q;
  logic [WORD_SIZE-1:0] pattern_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_q    <= 1'b0;
      pattern_q <= '0;
    end else if (load) begin
      fill_q    <= Fill;
      pattern_q <= FillPattern;
    end
  end

  assign fill_start = Fill;
  assign fill_mode  = fill_q;
  assign fill_word  = pattern_q;
`else
  assign fill_start = 1'b0;
  assign fill_mode  = 1'b0;
  assign fill_word  = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Read data arrives the cycle after MemRead, i.e. during WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_q <= '0;
    end else if (state_q == StWait) begin
      buf_q <= ReadData;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          if (Length == '0) begin
            state_d = StDone;
          end else begin
            state_d = fill_start ? StWrite : StRead;
          end
        end
      end
      StRead:  state_d = StWait;
      StWait:  state_d = StWrite;
      StWrite: begin
        if (cnt_zero_next) begin
          state_d = StDone;
        end else begin
          state_d = fill_mode ? StWrite : StRead;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    Busy      = 1'b0;
    Done      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Address   = '0;
    WriteData = '0;
    unique case (state_q)
      StRead: begin
        Busy    = 1'b1;
        MemRead = 1'b1;
        Address = src_ptr;
      end
      StWait: Busy = 1'b1;
      StWrite: begin
        Busy      = 1'b1;
        MemWrite  = 1'b1;
        Address   = dst_ptr;
        WriteData = fill_mode ? fill_word : buf_q;
      end
      StDone:  Done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_block_copier.sv
// Self-checking bench for mem_block_copier: table of copy vectors plus
// hand-written sequences for ignored Start, mid-transfer reset and fill mode.
module tb_mem_block_copier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Start;
  logic [31:0] SrcAddr;
  logic [31:0] DstAddr;
  logic [15:0] Length;
  logic        Busy;
  logic        Done;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] ReadData = '0;
`ifdef MEM_COPIER_FILL_EN
  logic        Fill;
  logic [31:0] FillPattern;
`endif

  always #5 clk = ~clk;

  mem_block_copier #(
    .WORD_SIZE   (32),
    .ADDRESS_SIZE(32),
    .LEN_SIZE    (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Start      (Start),
    .SrcAddr    (SrcAddr),
    .DstAddr    (DstAddr),
    .Length     (Length),
`ifdef MEM_COPIER_FILL_EN
    .Fill       (Fill),
    .FillPattern(FillPattern),
`endif
    .Busy       (Busy),
    .Done       (Done),
    .Address    (Address),
    .WriteData  (WriteData),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .ReadData   (ReadData)
  );

  // Memory model: untouched words hold a pattern derived from their address.
  logic [31:0] wmem [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic logic [31:0] mem_peek(input logic [31:0] a);
    return wmem.exists(a) ? wmem[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (MemRead) ReadData <= mem_peek(Address);
    if (MemWrite) wmem[Address] = WriteData;
  end

  logic [31:0] wr_a[$];
  logic [31:0] wr_d[$];
  logic [31:0] rd_a[$];
  int          both_cnt = 0;

  always @(negedge clk) begin
    if (MemWrite) begin
      wr_a.push_back(Address);
      wr_d.push_back(WriteData);
    end
    if (MemRead) rd_a.push_back(Address);
    if (MemRead && MemWrite) both_cnt++;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive_start(input logic [31:0] src, input logic [31:0] dst, input int len,
                             input bit fill, input logic [31:0] pat);
    Start   = 1'b1;
    SrcAddr = src;
    DstAddr = dst;
    Length  = 16'(len);
`ifdef MEM_COPIER_FILL_EN
    Fill        = fill;
    FillPattern = pat;
`else
    if (fill || pat != 0) $display("note: fill request ignored in copy-only build");
`endif
  endtask

  // Called at a negedge with the DUT idle; poke>0 re-pulses Start in that cycle.
  task automatic run_copy(input string name, input logic [31:0] src, input logic [31:0] dst,
                          input int len, input bit fill, input logic [31:0] pat,
                          input int poke, input int exp_done);
    logic [31:0] ea[$];
    logic [31:0] ed[$];
    logic [31:0] er[$];
    logic [31:0] sh [logic [31:0]];
    logic [31:0] a;
    logic [31:0] d;
    int          cyc;
    int          done_cyc;
    bit          busy_ok;

    for (int j = 0; j < len; j++) begin
      a = src + 32'(j);
      if (fill) d = pat;
      else begin
        d = sh.exists(a) ? sh[a] : mem_peek(a);
        er.push_back(a);
      end
      ea.push_back(dst + 32'(j));
      ed.push_back(d);
      sh[dst + 32'(j)] = d;
    end

    wr_a.delete();
    wr_d.delete();
    rd_a.delete();
    drive_start(src, dst, len, fill, pat);
    @(posedge clk);
    cyc      = 0;
    done_cyc = -1;
    busy_ok  = 1'b1;
    while (cyc < 300 && done_cyc < 0) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) Start = 1'b0;
      if (Done) begin
        done_cyc = cyc;
        if (Busy) busy_ok = 1'b0;
      end else if (!Busy) busy_ok = 1'b0;
      if (poke > 0 && cyc == poke) drive_start(src + 32'd77, dst + 32'd5, 1, !fill, ~pat);
      if (poke > 0 && cyc == poke + 1) Start = 1'b0;
    end
    Start = 1'b0;

    chk({name, ".done_cycle"}, 64'(done_cyc), 64'(exp_done));
    chk({name, ".busy_profile"}, 64'(busy_ok), 64'd1);
    chk({name, ".write_count"}, 64'(wr_a.size()), 64'(ea.size()));
    chk({name, ".read_count"}, 64'(rd_a.size()), 64'(er.size()));
    for (int j = 0; j < ea.size() && j < wr_a.size(); j++) begin
      chk($sformatf("%s.wr_addr[%0d]", name, j), 64'(wr_a[j]), 64'(ea[j]));
      chk($sformatf("%s.wr_data[%0d]", name, j), 64'(wr_d[j]), 64'(ed[j]));
    end
    for (int j = 0; j < er.size() && j < rd_a.size(); j++)
      chk($sformatf("%s.rd_addr[%0d]", name, j), 64'(rd_a[j]), 64'(er[j]));

    @(negedge clk);
    chk({name, ".idle_after"}, 64'({Busy, Done, MemRead, MemWrite}), 64'd0);
  endtask

  typedef struct {
    string       name;
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    int          exp_done;
  } vec_t;

  vec_t vecs[5];
  int   cyc;
  bit   saw_done;

  initial begin
    vecs[0] = '{name: "copy4",   src: 32'd100,        dst: 32'd200,  len: 4, exp_done: 13};
    vecs[1] = '{name: "len0",    src: 32'd5000,       dst: 32'd6000, len: 0, exp_done: 1};
    vecs[2] = '{name: "wrap",    src: 32'hFFFF_FFFE,  dst: 32'd10,   len: 3, exp_done: 10};
    vecs[3] = '{name: "overlap", src: 32'd300,        dst: 32'd301,  len: 3, exp_done: 10};
    vecs[4] = '{name: "copy1",   src: 32'd1000,       dst: 32'd500,  len: 1, exp_done: 4};

    rst_n   = 1'b0;
    Start   = 1'b0;
    SrcAddr = '0;
    DstAddr = '0;
    Length  = '0;
`ifdef MEM_COPIER_FILL_EN
    Fill        = 1'b0;
    FillPattern = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.Busy", 64'(Busy), 64'd0);
    chk("reset.Done", 64'(Done), 64'd0);
    chk("reset.MemRead", 64'(MemRead), 64'd0);
    chk("reset.MemWrite", 64'(MemWrite), 64'd0);
    chk("reset.Address", 64'(Address), 64'd0);
    chk("reset.WriteData", 64'(WriteData), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      run_copy(vecs[i].name, vecs[i].src, vecs[i].dst, vecs[i].len, 1'b0, 32'd0, 0,
               vecs[i].exp_done);

    // Re-pulsing Start with other arguments while busy must change nothing.
    run_copy("ignore_start", 32'd400, 32'd700, 4, 1'b0, 32'd0, 2, 13);

    // Reset in the WAIT cycle of word 2 (cycle 5) of a 4-word copy.
    wr_a.delete();
    wr_d.delete();
    rd_a.delete();
    drive_start(32'd100, 32'd600, 4, 1'b0, 32'd0);
    @(posedge clk);
    for (cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      if (cyc == 1) Start = 1'b0;
    end
    chk("rst_mid.wait_strobes", 64'({Busy, MemRead, MemWrite}), 64'b100);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid.outputs", 64'({Busy, Done, MemRead, MemWrite}), 64'd0);
    chk("rst_mid.Address", 64'(Address), 64'd0);
    chk("rst_mid.WriteData", 64'(WriteData), 64'd0);
    rst_n    = 1'b1;
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (Done) saw_done = 1'b1;
    end
    chk("rst_mid.no_done", 64'(saw_done), 64'd0);
    chk("rst_mid.write_count", 64'(wr_a.size()), 64'd1);
    if (wr_a.size() > 0) chk("rst_mid.wr_addr", 64'(wr_a[0]), 64'd600);

`ifdef MEM_COPIER_FILL_EN
    run_copy("fill3", 32'd0, 32'd50, 3, 1'b1, 32'hDEAD_BEEF, 0, 4);
    run_copy("fill_off", 32'd800, 32'd900, 2, 1'b0, 32'h1234_5678, 0, 7);
`endif

    chk("strobe_exclusive", 64'(both_cnt), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
